// File: rtl/stack_io_pkg.sv
// Shared constants and types for the stack processor I/O ports.
// Used by stack_in_port, the processor core and any future output port.
package stack_io_pkg;

    localparam int STACK_WORD_W           = 16;
    localparam int STACK_IN_DEPTH_DEFAULT = 4;
    localparam int STACK_IN_COUNT_W       = $clog2(STACK_IN_DEPTH_DEFAULT) + 1;

    typedef logic [STACK_WORD_W-1:0]     word_t;
    typedef logic [STACK_IN_COUNT_W-1:0] in_count_t;

    // Occupancy counter width for a FIFO of the given depth (must hold DEPTH itself).
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_in_fifo_mem.sv
// Storage array for the stack input FIFO: synchronous write, asynchronous read.
// Data is deliberately not reset; validity is tracked by the parent's pointers.
module stack_in_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_in_port.sv
// Input staging buffer feeding the stack processor's getin port.
//
// Handshake: a producer word transfers on a rising edge where in_valid and
// in_ready are both high; while in_valid is high and in_ready is low the
// producer holds in_data stable. A processor pop transfers on an edge where
// rd_en and getin_valid are both high; rd_en with getin_valid low is an
// illegal pop and sets the sticky underflow flag.
//
// Optional feature macro: STACK_IN_BYPASS_EN. When defined, an empty buffer
// forwards in_data straight to getin, and a full buffer with rd_en high also
// accepts a push (the only rd_en -> in_ready combinational path).
module stack_in_port
    import stack_io_pkg::*;
#(
    parameter int WIDTH = STACK_WORD_W,
    parameter int DEPTH = STACK_IN_DEPTH_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          getin,
    output logic                      getin_valid,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] head;
    logic             stored;
    logic             full;
    logic             direct;
    logic             wr_en;
    logic             pop_ok;

    assign stored = (count != '0);
    assign full   = (count == FULL_CNT);

`ifdef STACK_IN_BYPASS_EN
    // Empty buffer with a same-cycle pop hands the producer word straight through.
    assign direct      = !stored && in_valid && rd_en;
    assign in_ready    = !reset && (!full || rd_en);
    assign getin_valid = stored || in_valid;
    assign getin       = stored ? head : (in_valid ? in_data : '0);
`else
    assign direct      = 1'b0;
    assign in_ready    = !reset && !full;
    assign getin_valid = stored;
    assign getin       = stored ? head : '0;
`endif

    assign wr_en  = in_valid && in_ready && !direct;
    assign pop_ok = rd_en && stored;

    stack_in_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (head)
    );

    // Advance pointers and occupancy on push/pop; latch illegal pops until reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_en, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (rd_en && !getin_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_in_port.sv
// Self-checking bench for stack_in_port: directed literal checks plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_stack_in_port;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef STACK_IN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             rd_en = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] getin;
    logic             getin_valid;
    logic [2:0]       count;
    logic             underflow;

    always #5 CLK = ~CLK;

    stack_in_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rd_en       (rd_en),
        .getin       (getin),
        .getin_valid (getin_valid),
        .count       (count),
        .underflow   (underflow)
    );

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] exp_q[$];
    bit               model_uf = 1'b0;
    bit               last_push = 1'b0;

    // Apply the buffer's rules to a plain queue at every edge.
    always @(posedge CLK or posedge reset) begin
        int n;
        bit acc;
        if (reset) begin
            exp_q.delete();
            model_uf  = 1'b0;
            last_push = 1'b0;
        end else begin
            n = exp_q.size();
            acc = in_valid && ((n != DEPTH) || (BYP && rd_en));
            if (BYP && n == 0 && in_valid && rd_en) begin
                last_push = 1'b1;
            end else begin
                if (rd_en && n == 0) model_uf = 1'b1;
                if (rd_en && n > 0) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(in_data);
                last_push = acc;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge CLK) begin
        int n;
        logic [WIDTH-1:0] e_getin;
        bit e_valid;
        bit e_ready;
        if (run_cmp) begin
            n = exp_q.size();
            e_valid = (n != 0) || (BYP && in_valid);
            e_getin = (n != 0) ? exp_q[0] : ((BYP && in_valid) ? in_data : '0);
            e_ready = !reset && ((n != DEPTH) || (BYP && rd_en));
            check("cyc_getin", 32'(getin), 32'(e_getin));
            check("cyc_getin_valid", 32'(getin_valid), 32'(e_valid));
            check("cyc_count", 32'(count), 32'(n));
            check("cyc_in_ready", 32'(in_ready), 32'(e_ready));
            check("cyc_underflow", 32'(underflow), 32'(model_uf));
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r);
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0;
        rd_en    = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_getin_valid", 32'(getin_valid), 0);
        check("rst_getin", 32'(getin), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_underflow", 32'(underflow), 0);
        @(posedge CLK);
        #1 reset = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 1);
        check("rst_release_count", 32'(count), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] d;
        bit v;
        bit r;

        repeat (2) @(posedge CLK);
        #1;
        check("init_in_ready_in_reset", 32'(in_ready), 0);
        check("init_count", 32'(count), 0);
        check("init_getin", 32'(getin), 0);
        reset = 1'b0;
        #1;
        check("init_in_ready_after_release", 32'(in_ready), 1);
        run_cmp = 1'b1;

        // Consecutive pushes, then drain in order.
        drive(1'b1, 16'h13b0, 1'b0);
        check("t1_count1", 32'(count), 1);
        check("t1_getin_first", 32'(getin), 32'h13b0);
        drive(1'b1, 16'h0003, 1'b0);
        check("t1_count2", 32'(count), 2);
        drive(1'b1, 16'h0007, 1'b0);
        check("t1_count3", 32'(count), 3);
        drive(1'b0, 16'h0, 1'b1);
        check("t1_pop1_getin", 32'(getin), 32'h0003);
        drive(1'b0, 16'h0, 1'b1);
        check("t1_pop2_getin", 32'(getin), 32'h0007);
        drive(1'b0, 16'h0, 1'b1);
        check("t1_empty_getin", 32'(getin), 0);
        check("t1_empty_count", 32'(count), 0);

        // Fill, hold a word against a full buffer, pop one to admit it.
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b0);
        check("t2_full_count", 32'(count), 4);
        check("t2_full_in_ready", 32'(in_ready), 0);
        drive(1'b1, 16'h0005, 1'b0);
        check("t2_hold_count", 32'(count), 4);
        check("t2_hold_getin", 32'(getin), 32'h1);
        drive(1'b1, 16'h0005, 1'b1);
        check("t2_pop_getin", 32'(getin), 32'h2);
        check("t2_pop_in_ready", 32'(in_ready), 1);
        check("t2_pop_count", 32'(count), BYP ? 4 : 3);
        drive(1'b1, 16'h0005, 1'b0);
        check("t2_accept_count", 32'(count), 4);
        for (int i = 2; i <= 5; i++) begin
            check("t2_drain_getin", 32'(getin), 32'(i));
            drive(1'b0, 16'h0, 1'b1);
        end
        check("t2_drained_count", 32'(count), 0);

        // Sustained push+pop at count 2; pointers wrap several times.
        drive(1'b1, 16'h0010, 1'b0);
        drive(1'b1, 16'h0011, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h0020 + i), 1'b1);
            check("t3_count", 32'(count), 2);
            check("t3_getin", 32'(getin), (i == 0) ? 32'h11 : 32'(32'h20 + i - 1));
        end
        drive(1'b0, 16'h0, 1'b1);
        check("t3_tail1", 32'(getin), 32'h29);
        drive(1'b0, 16'h0, 1'b1);
        check("t3_tail_empty", 32'(getin), 0);

        // Illegal pop while empty; flag is sticky, buffer still works.
        drive(1'b0, 16'h0, 1'b1);
        check("t4_underflow", 32'(underflow), 1);
        check("t4_count", 32'(count), 0);
        check("t4_getin", 32'(getin), 0);
        drive(1'b1, 16'h0077, 1'b0);
        check("t4_push_getin", 32'(getin), 32'h77);
        drive(1'b0, 16'h0, 1'b1);
        check("t4_pop_count", 32'(count), 0);
        check("t4_underflow_sticky", 32'(underflow), 1);

        // Asynchronous reset with words stored.
        drive(1'b1, 16'h00a1, 1'b0);
        drive(1'b1, 16'h00a2, 1'b0);
        drive(1'b1, 16'h00a3, 1'b0);
        check("t5_count3", 32'(count), 3);
        reset_pulse();

`ifdef STACK_IN_BYPASS_EN
        // Bypass: a word offered to an empty buffer with a pop goes straight through.
        in_valid = 1'b1;
        in_data  = 16'h00aa;
        rd_en    = 1'b1;
        #1;
        check("byp_getin", 32'(getin), 32'haa);
        check("byp_getin_valid", 32'(getin_valid), 1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        #1;
        check("byp_count", 32'(count), 0);
        check("byp_underflow", 32'(underflow), 0);
`endif

        // Randomized traffic; a refused word is held stable until accepted.
        for (int i = 0; i < 400; i++) begin
            if (in_valid && !last_push) begin
                v = 1'b1;
                d = in_data;
            end else begin
                v = 1'($urandom_range(0, 1));
                d = 16'($urandom);
            end
            r = ($urandom_range(0, 99) < 45);
            drive(v, d, r);
            if (i == 200) reset_pulse();
        end

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_in_port.md
# stack_in_port

Input staging buffer that sits directly upstream of the stack processor's `getin` port. It accepts 16-bit words from an external producer over a valid/ready handshake and holds them in a small FIFO. It presents the oldest word to the processor, which pops it with `rd_en` when it executes an input instruction. Status outputs let the processor and the bench see fill level and illegal pops.

## Interface
- `WIDTH`, 16, data word width; matches the processor stack word.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `CLK`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  producer word.
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  buffer can accept a word this cycle.
- `rd_en`  in  1  processor pop of the head word.
- `getin`  out  WIDTH  head word to the processor; 0 when empty.
- `getin_valid`  out  1  `getin` holds a real word.
- `count`  out  $clog2(DEPTH)+1  words currently stored.
- `underflow`  out  1  sticky; set by a pop while no word is available.

## Operation
- The FIFO is a circular buffer with write and read pointers of $clog2(DEPTH) bits plus an occupancy counter. Pointers wrap DEPTH-1 → 0.
- Push: `in_valid && in_ready` at the rising edge writes `in_data` at wptr, advances wptr and increments `count`.
- Pop: `rd_en && getin_valid` at the edge advances rptr and decrements `count`.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- `in_ready = (count != DEPTH)`. It is registered-state-derived only, with no combinational path from `rd_en`. When the buffer is full, a same-cycle pop does not open a slot for a same-cycle push.
- `getin` equals the memory entry at rptr when `count != 0`, and 0 otherwise. `getin_valid = (count != 0)`.
- `rd_en` while `getin_valid` is 0:
  - No pointer or count change.
  - `underflow` is set and stays set until reset.
- When `in_valid` is held while `in_ready` is low, the producer must keep `in_data` stable. Nothing is dropped.
- Reset, asserted at any time including mid-transfer, behaves as follows:
  - Pointers and `count` go to 0, `underflow` to 0, `getin` to 0, `getin_valid` to 0.
  - Stored contents are discarded.
  - `in_ready` is 0 while `reset` is high and 1 on the first cycle after release.

## Timing
- Push-to-visible latency is 1 cycle: a word written at edge N appears on `getin` with `getin_valid` = 1 after edge N.
- Pop takes effect at the edge. The next word, or 0 if the buffer is now empty, is on `getin` after that edge.
- `count`, `in_ready` and `getin_valid` all update on the same edge as the push or pop that changes them.
- Throughput is one push and one pop per cycle, sustained when 0 < count < DEPTH.
- `underflow` rises on the edge at which the illegal pop is sampled.

## Configuration
- `STACK_IN_BYPASS_EN` defined:
  - When `count == 0` and `in_valid` is high, `getin = in_data` and `getin_valid = 1` combinationally.
  - A same-cycle `rd_en` consumes the word directly: no write, `count` stays 0, `underflow` is not set.
  - `in_ready` is also 1 when full and `rd_en` is high. This makes the case the only combinational path from `rd_en`.
- `STACK_IN_BYPASS_EN` not defined: operation is exactly as described above, with 1-cycle minimum latency and no `rd_en`→`in_ready` path.

## Structure
- Shared package `stack_io_pkg`:
  - `STACK_WORD_W` = 16.
  - `STACK_IN_DEPTH_DEFAULT` = 4.
  - Count-width constant and a `word_t` typedef, reused by the processor and any future output port.
- Sub-module `stack_in_fifo_mem`: a DEPTH×WIDTH register array with a synchronous write port and an asynchronous read port. It has no reset on data, only on the parent's pointers.

## Test plan
- Reset, then push 0x13b0, 0x0003, 0x0007 on consecutive cycles without popping → `count` reads 1, 2, 3 after each edge; `getin` = 0x13b0 one cycle after the first push.
- Fill to 4 words (0x1, 0x2, 0x3, 0x4) and hold `in_valid` with 0x5 → `in_ready` = 0 and 0x5 is not written. Then one pop → `getin` = 0x2 and `in_ready` = 1; 0x5 is accepted on the following edge, giving `count` = 4.
- Simultaneous push and pop every cycle for 10 cycles at `count` = 2 → `count` stays 2, output order matches input order, and both pointers wrap cleanly.
- Pop while empty → `underflow` = 1 and stays high. `count` = 0, `getin` = 0, and a later push/pop sequence works normally.
- Assert `reset` for one cycle with 3 words stored → all outputs return to reset values and `in_ready` = 1 after release. With `STACK_IN_BYPASS_EN`, push 0x00AA with `rd_en` while empty → `getin` = 0x00AA in the same cycle, `count` stays 0, `underflow` stays 0.
